// File: rtl/alu_issue_if.sv
// alu_issue_if: issue handshake bundle (input op + register data, flush, registered ALU op output, issue counter)
interface alu_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] oprnd1;
  logic [31:0] oprnd2;
  logic [3:0]  opr;
  logic [4:0]  rd;
  logic        illegal;
  logic [31:0] issue_cnt;
  modport master (
    output in_valid, instr, rs1_data, rs2_data, flush, out_ready,
    input  in_ready, out_valid, oprnd1, oprnd2, opr, rd, illegal, issue_cnt
  );
  modport slave (
    input  in_valid, instr, rs1_data, rs2_data, flush, out_ready,
    output in_ready, out_valid, oprnd1, oprnd2, opr, rd, illegal, issue_cnt
  );
endinterface

// File: rtl/alu_issue.sv
// alu_issue: decodes RV32I OP/OP-IMM/LUI into a single-entry registered ALU op (clk, rst, bus=alu_issue_if.slave)
module alu_issue (
  input logic        clk,
  input logic        rst,
  alu_issue_if.slave bus
);
  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, XOR = 4'd2, OR = 4'd3, AND = 4'd4;
  localparam logic [3:0] SLL = 4'd5, SRL = 4'd6, SRA = 4'd7, SLT = 4'd8, SLTU = 4'd9;
  function automatic logic [3:0] f3_opr(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? SUB : ADD;
      3'd1:    return SLL;
      3'd2:    return SLT;
      3'd3:    return SLTU;
      3'd4:    return XOR;
      3'd5:    return alt ? SRA : SRL;
      3'd6:    return OR;
      default: return AND;
    endcase
  endfunction
  logic        vld_q, vld_d, ill_q, ill_d;
  logic [31:0] op1_q, op1_d, op2_q, op2_d, cnt_q, cnt_d;
  logic [3:0]  opr_q, opr_d;
  logic [4:0]  rd_q, rd_d;
  logic        dec_ill;
  logic [3:0]  dec_opr;
  logic [31:0] dec_op1, dec_op2;
  logic [4:0]  dec_rd;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        shift_imm, accept, consume;
  assign f3        = bus.instr[14:12];
  assign f7        = bus.instr[31:25];
  assign shift_imm = f3 == 3'd1 || f3 == 3'd5;
  assign bus.in_ready = !bus.flush && (!vld_q || bus.out_ready);
  assign accept    = bus.in_valid && bus.in_ready;
  assign consume   = vld_q && bus.out_ready && !bus.flush;
  always_comb begin
    dec_ill = 1'b0;
    dec_opr = ADD;
    dec_op1 = bus.rs1_data;
    dec_op2 = bus.rs2_data;
    dec_rd  = bus.instr[11:7];
    case (bus.instr[6:0])
      7'b0110011: begin
        dec_opr = f3_opr(f3, f7[5]);
        dec_ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
      end
      7'b0010011: begin
        // ADDI's imm[10] shares the SUB/SRA bit, so only SRAI may select the alternate op
        dec_opr = f3_opr(f3, f3 == 3'd5 && f7 == 7'h20);
        dec_op2 = shift_imm ? {27'b0, bus.instr[24:20]} : {{20{bus.instr[31]}}, bus.instr[31:20]};
        dec_ill = f3 == 3'd1 ? f7 != 7'h00 : f3 == 3'd5 ? !(f7 == 7'h00 || f7 == 7'h20) : 1'b0;
      end
      7'b0110111: begin
        dec_op1 = '0;
        dec_op2 = {bus.instr[31:12], 12'b0};
      end
      default: dec_ill = 1'b1;
    endcase
    if (dec_ill) begin
      dec_opr = ADD;
      dec_op1 = '0;
      dec_op2 = '0;
      dec_rd  = '0;
    end
  end
  always_comb begin
    vld_d = bus.flush ? 1'b0 : accept ? 1'b1 : bus.out_ready ? 1'b0 : vld_q;
    ill_d = accept ? dec_ill : ill_q;
    opr_d = accept ? dec_opr : opr_q;
    op1_d = accept ? dec_op1 : op1_q;
    op2_d = accept ? dec_op2 : op2_q;
    rd_d  = accept ? dec_rd : rd_q;
    cnt_d = cnt_q + {31'b0, consume};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= 1'b0;
      ill_q <= 1'b0;
      opr_q <= '0;
      op1_q <= '0;
      op2_q <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      ill_q <= ill_d;
      opr_q <= opr_d;
      op1_q <= op1_d;
      op2_q <= op2_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  assign bus.out_valid = vld_q;
  assign bus.illegal   = ill_q;
  assign bus.opr       = opr_q;
  assign bus.oprnd1    = op1_q;
  assign bus.oprnd2    = op2_q;
  assign bus.rd        = rd_q;
  assign bus.issue_cnt = cnt_q;
endmodule
